// File: rtl/ntt_pkg.sv
// Shared NTT definitions: datapath mode codes, bank occupancy states and a
// bit-reversal helper used to build inverse-NTT lane/beat orderings.
package ntt_pkg;

    localparam logic [2:0] MODE_FORWARD_NTT = 3'd0;
    localparam logic [2:0] MODE_INVERSE_NTT = 3'd1;
    localparam logic [2:0] MODE_MULT        = 3'd2;
    localparam logic [2:0] MODE_ADD         = 3'd3;
    localparam logic [2:0] MODE_SUB         = 3'd4;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Reverses the low 'bits' bits of 'value'; higher bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
        logic [31:0] rev;
        rev = 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (b < int'(bits)) begin
                rev[int'(bits) - 1 - b] = value[b];
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/ntt_transpose_bank.sv
// One LANES x LANES coefficient block: row-write port, per-block mode register
// and a combinational column/row read mux selected by the latched mode.
module ntt_transpose_bank
    import ntt_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int COEF_W = 24,
    localparam int CNT_W  = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      srst,
    input  logic                      wr_en,
    input  logic [CNT_W-1:0]          wr_row,
    input  logic [LANES*COEF_W-1:0]   wr_data,
    input  logic                      mode_we,
    input  logic [2:0]                mode,
    input  logic [CNT_W-1:0]          rd_col,
    output logic [2:0]                blk_mode,
    output logic [LANES*COEF_W-1:0]   rd_data
);

    logic [LANES-1:0][LANES-1:0][COEF_W-1:0] mem_r;
    logic [LANES-1:0][LANES-1:0][COEF_W-1:0] mem_rev_s;
    logic [2:0]                              mode_r;

    // Row storage: beat r of a block lands in row r; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_row] <= wr_data;
        end
    end

    // Mode captured on the first beat, held until the next block starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_FORWARD_NTT;
        end else if (srst) begin
            mode_r <= MODE_FORWARD_NTT;
        end else if (mode_we) begin
            mode_r <= mode;
        end
    end

    assign blk_mode = mode_r;

    // Statically permuted view so the inverse read uses the same index as forward.
    for (genvar r = 0; r < LANES; r++) begin : g_rev_row
        for (genvar k = 0; k < LANES; k++) begin : g_rev_col
            localparam int REV_R = int'(bitrev(32'(r), CNT_W));
            localparam int REV_K = int'(bitrev(32'(k), CNT_W));
            assign mem_rev_s[r][k] = mem_r[REV_R][REV_K];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [COEF_W-1:0] lane_s;

        // Per-lane read mux: transpose, bit-reversed transpose, or pass-through row.
        always_comb begin
            case (mode_r)
                MODE_FORWARD_NTT: lane_s = mem_r[g][rd_col];
                MODE_INVERSE_NTT: lane_s = mem_rev_s[g][rd_col];
                default:          lane_s = mem_r[rd_col][g];
            endcase
        end

        assign rd_data[g*COEF_W +: COEF_W] = lane_s;
    end

endmodule

// File: rtl/ntt_lane_transpose.sv
// Double-buffered lane-reorder buffer: fills one bank while draining the other,
// with valid/ready handshakes on both sides and a synchronous flush.
module ntt_lane_transpose
    import ntt_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int COEF_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [2:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*COEF_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*COEF_W-1:0]   out_data,
    output logic [2:0]                out_mode,
    output logic                      busy
);

    localparam int              CNT_W     = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LANES - 1);

    bank_state_e                bank_state_r [2];
    bank_state_e                bank_state_s [2];
    logic                       wr_bank_r, wr_bank_s;
    logic                       rd_bank_r, rd_bank_s;
    logic [CNT_W-1:0]           wr_cnt_r, wr_cnt_s;
    logic [CNT_W-1:0]           rd_cnt_r, rd_cnt_s;
    logic                       in_fire_s;
    logic                       out_fire_s;
    logic [1:0]                 bank_wr_en_s;
    logic [2:0]                 bank_mode_s [2];
    logic [LANES*COEF_W-1:0]    bank_rd_data_s [2];

    assign in_ready   = (bank_state_r[wr_bank_r] != BANK_FULL);
    assign out_valid  = (bank_state_r[rd_bank_r] == BANK_FULL);
    assign busy       = (bank_state_r[0] != BANK_EMPTY) || (bank_state_r[1] != BANK_EMPTY);
    // Flush wins over both handshakes in the same cycle.
    assign in_fire_s  = in_valid && in_ready && !flush;
    assign out_fire_s = out_valid && out_ready && !flush;

    // Next-state for bank occupancy plus write and read pointers/counters.
    always_comb begin
        bank_state_s = bank_state_r;
        wr_bank_s    = wr_bank_r;
        wr_cnt_s     = wr_cnt_r;
        rd_bank_s    = rd_bank_r;
        rd_cnt_s     = rd_cnt_r;
        if (flush) begin
            bank_state_s[0] = BANK_EMPTY;
            bank_state_s[1] = BANK_EMPTY;
            wr_bank_s       = 1'b0;
            wr_cnt_s        = '0;
            rd_bank_s       = 1'b0;
            rd_cnt_s        = '0;
        end else begin
            if (in_fire_s) begin
                if (wr_cnt_r == LAST_BEAT) begin
                    bank_state_s[wr_bank_r] = BANK_FULL;
                    wr_bank_s               = ~wr_bank_r;
                    wr_cnt_s                = '0;
                end else begin
                    bank_state_s[wr_bank_r] = BANK_FILLING;
                    wr_cnt_s                = wr_cnt_r + CNT_W'(1);
                end
            end else begin
                wr_cnt_s = wr_cnt_r;
            end
            if (out_fire_s) begin
                if (rd_cnt_r == LAST_BEAT) begin
                    bank_state_s[rd_bank_r] = BANK_EMPTY;
                    rd_bank_s               = ~rd_bank_r;
                    rd_cnt_s                = '0;
                end else begin
                    rd_cnt_s = rd_cnt_r + CNT_W'(1);
                end
            end else begin
                rd_cnt_s = rd_cnt_r;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state_r[0] <= BANK_EMPTY;
            bank_state_r[1] <= BANK_EMPTY;
            wr_bank_r       <= 1'b0;
            wr_cnt_r        <= '0;
            rd_bank_r       <= 1'b0;
            rd_cnt_r        <= '0;
        end else begin
            bank_state_r <= bank_state_s;
            wr_bank_r    <= wr_bank_s;
            wr_cnt_r     <= wr_cnt_s;
            rd_bank_r    <= rd_bank_s;
            rd_cnt_r     <= rd_cnt_s;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_wr_en_s[b] = in_fire_s && (wr_bank_r == 1'(b));

        ntt_transpose_bank #(
            .LANES  (LANES),
            .COEF_W (COEF_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .srst     (flush),
            .wr_en    (bank_wr_en_s[b]),
            .wr_row   (wr_cnt_r),
            .wr_data  (in_data),
            .mode_we  (bank_wr_en_s[b] && (wr_cnt_r == '0)),
            .mode     (mode),
            .rd_col   (rd_cnt_r),
            .blk_mode (bank_mode_s[b]),
            .rd_data  (bank_rd_data_s[b])
        );
    end

    // Output mux from the read bank, forced to zero while nothing is offered.
    always_comb begin
        if (out_valid) begin
            out_data = bank_rd_data_s[rd_bank_r];
            out_mode = bank_mode_s[rd_bank_r];
        end else begin
            out_data = '0;
            out_mode = MODE_FORWARD_NTT;
        end
    end

endmodule

// File: tb/tb_ntt_lane_transpose.sv
// Randomised bench for ntt_lane_transpose against a block-queue reference model.
module tb_ntt_lane_transpose;

    localparam int LANES  = 4;
    localparam int COEF_W = 24;
    localparam int CNT_W  = 2;
    localparam int BW     = LANES * COEF_W;
    localparam int BLK_W  = LANES * BW;
    localparam int OBS_W  = 6 + BW;
    localparam logic [OBS_W-1:0] RESET_OBS = {1'b0, 1'b1, 1'b0, 3'd0, {BW{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]    mode, out_mode;
    logic [BW-1:0] in_data, out_data;

    always #5 clk = ~clk;

    ntt_lane_transpose #(.LANES(LANES), .COEF_W(COEF_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    wire [OBS_W-1:0] obs = {out_valid, in_ready, busy, out_mode, out_data};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: completed blocks waiting for output, plus the block being filled.
    logic [BLK_W-1:0] full_q[$];
    logic [2:0]       fmode_q[$];
    logic [BLK_W-1:0] cur_blk;
    logic [2:0]       cur_mode;
    int               cur_cnt = 0;
    int               rd_j = 0;

    function automatic int rev(input int v);
        int r = 0;
        for (int b = 0; b < CNT_W; b++) if (((v >> b) & 1) == 1) r += 1 << (CNT_W - 1 - b);
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_beat(input logic [BLK_W-1:0] blk, input logic [2:0] md, input int j);
        logic [BW-1:0] o;
        int row, col;
        for (int i = 0; i < LANES; i++) begin
            if (md == 3'd0)      begin row = i;      col = j;      end
            else if (md == 3'd1) begin row = rev(i); col = rev(j); end
            else                 begin row = j;      col = i;      end
            o[i*COEF_W +: COEF_W] = blk[(row*LANES + col)*COEF_W +: COEF_W];
        end
        return o;
    endfunction

    function automatic logic [OBS_W-1:0] exp_obs();
        logic          v;
        logic [BW-1:0] d;
        logic [2:0]    m;
        v = full_q.size() > 0;
        d = '0;
        m = 3'd0;
        if (v) begin
            d = exp_beat(full_q[0], fmode_q[0], rd_j);
            m = fmode_q[0];
        end
        return {v, full_q.size() < 2, v || (cur_cnt > 0), m, d};
    endfunction

    function automatic logic [BW-1:0] pat(input int r, input int off);
        logic [BW-1:0] d;
        for (int c = 0; c < LANES; c++) d[c*COEF_W +: COEF_W] = COEF_W'(off + 16*r + c);
        return d;
    endfunction

    function automatic logic [BW-1:0] rnd();
        logic [BW-1:0] d;
        for (int c = 0; c < LANES; c++) d[c*COEF_W +: COEF_W] = COEF_W'($urandom);
        return d;
    endfunction

    task automatic model_clear();
        full_q.delete();
        fmode_q.delete();
        cur_cnt = 0;
        rd_j = 0;
    endtask

    task automatic drive(input logic v, input logic [BW-1:0] d, input logic [2:0] m,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic advance();
        bit in_f, out_f;
        @(posedge clk);
        in_f  = in_valid && (full_q.size() < 2) && !flush;
        out_f = (full_q.size() > 0) && out_ready && !flush;
        if (flush) begin
            model_clear();
        end else begin
            if (out_f) begin
                rd_j++;
                if (rd_j == LANES) begin
                    rd_j = 0;
                    void'(full_q.pop_front());
                    void'(fmode_q.pop_front());
                end
            end
            if (in_f) begin
                if (cur_cnt == 0) cur_mode = mode;
                cur_blk[cur_cnt*BW +: BW] = in_data;
                cur_cnt++;
                if (cur_cnt == LANES) begin
                    full_q.push_back(cur_blk);
                    fmode_q.push_back(cur_mode);
                    cur_cnt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic start_clean();
        drive(1'b0, '0, 3'd0, 1'b1, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL reset_held: got %h need %h", obs, RESET_OBS);
        end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL reset_released: got %h need %h", obs, RESET_OBS);
        end
        advance();
    endtask

    task automatic test_forward();
        logic [BW-1:0] want;
        start_clean();
        for (int c = 0; c < 9; c++) begin
            if (c < LANES) drive(1'b1, pat(c, 0), 3'd0, 1'b1, 1'b0);
            else           drive(1'b0, rnd(), 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL forward c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c == 3 || c == 4 || c == 7) begin
                for (int i = 0; i < LANES; i++) want[i*COEF_W +: COEF_W] = COEF_W'(16*i + (c - 4));
                vectors++;
                if (c == 3 && out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL forward_early_valid: got %b need 0", out_valid);
                end else if (c != 3 && (out_valid !== 1'b1 || out_data !== want)) begin
                    miscompares++;
                    $display("FAIL forward_beat%0d: got v=%b d=%h need v=1 d=%h", c - 4, out_valid, out_data, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_inverse();
        logic [BW-1:0] want;
        int base[4] = '{0, 32, 16, 48};
        int off;
        start_clean();
        for (int c = 0; c < 9; c++) begin
            if (c < LANES) drive(1'b1, pat(c, 0), 3'd1, 1'b1, 1'b0);
            else           drive(1'b0, rnd(), 3'd2, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL inverse c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c == 4 || c == 5 || c == 7) begin
                off = (c == 4) ? 0 : (c == 5) ? 2 : 3;
                for (int i = 0; i < LANES; i++) want[i*COEF_W +: COEF_W] = COEF_W'(base[i] + off);
                vectors++;
                if (out_valid !== 1'b1 || out_mode !== 3'd1 || out_data !== want) begin
                    miscompares++;
                    $display("FAIL inverse_beat%0d: got v=%b m=%0d d=%h need v=1 m=1 d=%h", c - 4, out_valid, out_mode, out_data, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_mode_switch();
        logic [BW-1:0] beats[8];
        logic [2:0]    m;
        start_clean();
        for (int k = 0; k < 8; k++) beats[k] = rnd();
        for (int c = 0; c < 14; c++) begin
            m = (c < 2) ? 3'd3 : 3'd0;
            if (c < 8) drive(1'b1, beats[c], m, 1'b1, 1'b0);
            else       drive(1'b0, rnd(), 3'd4, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL mode_switch c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c >= 4 && c < 8) begin
                vectors++;
                if (out_mode !== 3'd3 || out_data !== beats[c-4]) begin
                    miscompares++;
                    $display("FAIL add_row%0d: got m=%0d d=%h need m=3 d=%h", c - 4, out_mode, out_data, beats[c-4]);
                end
            end else if (c >= 8 && c < 12) begin
                vectors++;
                if (out_valid !== 1'b1 || out_mode !== 3'd0) begin
                    miscompares++;
                    $display("FAIL next_block_mode c%0d: got v=%b m=%0d need v=1 m=0", c, out_valid, out_mode);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        start_clean();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, rnd(), 3'($urandom_range(4, 0)), 1'b0, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs() || in_ready !== (c < 8)) begin
                miscompares++;
                $display("FAIL backpressure_fill c%0d: got %h need %h (in_ready need %0d)", c, obs, exp_obs(), c < 8);
            end
            advance();
        end
        for (int d = 0; d < 10; d++) begin
            drive(1'b0, rnd(), 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL backpressure_drain d%0d: got %h need %h", d, obs, exp_obs());
            end
            if (d < 6) begin
                vectors++;
                if (in_ready !== (d >= 4)) begin
                    miscompares++;
                    $display("FAIL backpressure_ready d%0d: got %b need %0d", d, in_ready, d >= 4);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] want;
        int blk, j;
        start_clean();
        for (int c = 0; c < 18; c++) begin
            if (c < 12) drive(1'b1, pat(c % 4, (c / 4) << 8), 3'd0, 1'b1, 1'b0);
            else        drive(1'b0, rnd(), 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c >= 4 && c < 16) begin
                blk = (c - 4) / 4;
                j   = (c - 4) % 4;
                for (int i = 0; i < LANES; i++) want[i*COEF_W +: COEF_W] = COEF_W'((blk << 8) + 16*i + j);
                vectors++;
                if (out_valid !== 1'b1 || out_data !== want || (c < 12 && in_ready !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL stream c%0d: got v=%b r=%b d=%h need v=1 d=%h", c, out_valid, in_ready, out_data, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        logic [BW-1:0] want;
        start_clean();
        for (int c = 0; c < 13; c++) begin
            if (c < 3)       drive(1'b1, pat(c, 12'hA00), 3'd1, 1'b1, 1'b0);
            else if (c == 3) drive(1'b1, pat(3, 12'hA00), 3'd1, 1'b1, 1'b1);
            else if (c < 8)  drive(1'b1, pat(c - 4, 12'hB00), 3'd0, 1'b1, 1'b0);
            else             drive(1'b0, rnd(), 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL flush c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c == 4) begin
                vectors++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_clear: got busy=%b v=%b need busy=0 v=0", busy, out_valid);
                end
            end else if (c >= 8 && c < 12) begin
                for (int i = 0; i < LANES; i++) want[i*COEF_W +: COEF_W] = COEF_W'(12'hB00 + 16*i + (c - 8));
                vectors++;
                if (out_valid !== 1'b1 || out_data !== want) begin
                    miscompares++;
                    $display("FAIL flush_newblock c%0d: got v=%b d=%h need v=1 d=%h", c, out_valid, out_data, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        start_clean();
        for (int c = 0; c < 7; c++) begin
            if (c < LANES) drive(1'b1, rnd(), 3'd2, 1'b1, 1'b0);
            else           drive(1'b1, rnd(), 3'd2, 1'b1, 1'b0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL async_pre c%0d: got %h need %h", c, obs, exp_obs());
            end
            if (c < 6) advance();
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL async_reset: got %h need %h", obs, RESET_OBS);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL async_release: got %h need %h", obs, RESET_OBS);
        end
        advance();
    endtask

    task automatic test_random();
        start_clean();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(3, 0) != 0), rnd(), 3'($urandom_range(4, 0)),
                  1'($urandom_range(2, 0) != 0), 1'($urandom_range(40, 0) == 0));
            @(negedge clk);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h need %h", c, obs, exp_obs());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_mode_switch();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_lane_transpose.md
# ntt_lane_transpose

- Parametrised, double-buffered lane-reorder buffer for the NTT datapath.
- Accepts one beat of `LANES` coefficients per cycle and collects `LANES` beats into a `LANES×LANES` block.
- Emits each block transposed (forward NTT), transposed with bit-reversed lane and beat order (inverse NTT), or unchanged (all other modes).
- Sits between the butterfly array and coefficient memory. Generalises the fixed 4-lane, 24-bit PISO reordering FIFO with arbitrary lane count and width, valid/ready handshakes, per-block mode latching, flush, and bubble-free streaming.

## Interface
Parameters:
- `LANES`, 4, coefficients per beat; power of two, ≥2.
- `COEF_W`, 24, bits per coefficient.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous discard of all buffered data.
- `mode` in 3: 0 FORWARD_NTT, 1 INVERSE_NTT, 2 MULT, 3 ADD, 4 SUB; sampled on the first beat of each block.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_data` in `LANES*COEF_W`: lane i = `in_data[i*COEF_W +: COEF_W]`.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out `LANES*COEF_W`: same lane packing as `in_data`.
- `out_mode` out 3: mode latched for the block currently being output.
- `busy` out 1: any bank not EMPTY.

## Operation
- Two banks, B0 and B1. Each bank holds `M[row][col]` plus a latched mode and a state: EMPTY → FILLING → FULL → EMPTY.
- Write side:
  - The pointer `wr_bank` and beat counter `wr_cnt` (log2 LANES bits) select where each accepted beat goes; beat `wr_cnt` writes `M[wr_cnt][*] = in_data`.
  - On `wr_cnt`=0 the bank's mode is latched from `mode`. A `mode` change mid-block is ignored until the next block.
  - On `wr_cnt`=LANES-1 the bank goes FULL, `wr_bank` toggles and `wr_cnt` wraps to 0.
- Read side: `rd_bank` and `rd_cnt` = j. Output lane i is:
  - FORWARD: `M[i][j]`.
  - INVERSE: `M[bitrev(i)][bitrev(j)]`, where bitrev is over log2 LANES bits.
  - Other modes: `M[j][i]`.
- On the last read handshake (j=LANES-1) the bank goes EMPTY, `rd_bank` toggles and `rd_cnt` wraps to 0.
- `in_ready` = bank[`wr_bank`] not FULL. `out_valid` = bank[`rd_bank`] FULL. `out_data` = 0 whenever `out_valid`=0.
- Accepted input beats are never dropped except by `flush` or reset. Output is strictly in block order.
- `flush`: all banks go EMPTY and pointers and counters clear at that edge. Any handshakes in the same cycle are discarded. Flush beats both in and out handshakes.
- Simultaneous events:
  - A write into one bank and a read from the other in the same cycle are independent.
  - A bank freed at an edge is writable in the next cycle.

## Timing
- Reset values: all banks EMPTY, pointers and counters 0, `out_valid`=0, `out_data`=0, `out_mode`=0, `busy`=0, `in_ready`=1. Storage arrays are not reset.
- Asserting `rst_n` low mid-operation discards partial and full blocks immediately (asynchronous).
- Latency: if beat k of a block is accepted in cycle k (k=0..LANES-1), `out_valid` rises in cycle LANES and output beat j appears in cycle LANES+j with `out_ready`=1.
- Throughput: 1 beat/cycle sustained with both handshakes continuously asserted; no bubbles at block boundaries.
- Backpressure: with `out_ready`=0, exactly 2·LANES beats are accepted, then `in_ready`=0.
- `out_data` and `out_valid` are held stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `ntt_pkg`: mode localparams (shared with the existing NTT control) and a `bitrev(value, bits)` function.
- One sub-module, `ntt_transpose_bank`: a single `LANES×LANES×COEF_W` register array with a row-write port, a latched mode register, and a combinational read mux taking (mode, j). It is instantiated twice.
- The top level holds the bank state machines, pointers, counters and handshake logic.

## Test plan
Default parameters. Block input beat r, lane c = 16r+c (hex 0xRC).

- **FORWARD streaming:** 4 beats from cycle 0, `out_ready`=1 → `out_valid` at cycle 4. Beat 0 lanes 0..3 = 0x00,0x10,0x20,0x30; beat 3 = 0x03,0x13,0x23,0x33.
- **INVERSE:** same input → beat 0 = 0x00,0x20,0x10,0x30; beat 1 = 0x02,0x22,0x12,0x32; beat 3 = 0x03,0x23,0x13,0x33. `out_mode`=1.
- **ADD mode, then mode switch:** ADD block beat j = row j. The mode changes to FORWARD at beat 2 of that block → the block is still output as ADD, and the next block is output as FORWARD.
- **Backpressure:** `out_ready`=0 with `in_valid`=1 for 10 cycles → 8 beats accepted, `in_ready`=0 from cycle 8. Then `out_ready`=1 → `in_ready` returns the cycle after the 4th output beat, and the data stays correct.
- **Continuous 3 blocks:** both handshakes high → 12 output beats in cycles 4..15 with no gaps, matching the FORWARD pattern per block.
- **Flush and reset:** `flush` after beat 2, then a new block → the output contains only the new block. Pulsing `rst_n` low mid-drain → all outputs return immediately to their reset values.
